// File: rtl/multi_strobe_tagger_pkg.sv
// Shared definitions for the strobe tagger: record layout helpers and the arm FSM states.
// Record layout, MSB to LSB: {rollover, chan_mask[N_CH-1:0], ts[TS_W-1:0]}.
package multi_strobe_tagger_pkg;

    typedef enum logic [1:0] {
        StArm0,
        StArm1,
        StArm2,
        StLive
    } arm_state_e;

    function automatic int unsigned rec_w(input int unsigned n_ch, input int unsigned ts_w);
        return 1 + n_ch + ts_w;
    endfunction

    function automatic int unsigned ts_lsb();
        return 0;
    endfunction

    function automatic int unsigned mask_lsb(input int unsigned ts_w);
        return ts_w;
    endfunction

    function automatic int unsigned rollover_bit(input int unsigned n_ch, input int unsigned ts_w);
        return n_ch + ts_w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with a registered read port and full/empty flags.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] data_q, data_d;
    logic             empty_q, empty_d;
    logic             full;
    logic             push;
    logic             pop;

    assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop  = rd_en_i & ~empty_q;
    // A read in the same cycle frees a slot, so a write into a full FIFO still lands.
    assign push = wr_en_i & (~full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        empty_d  = (wr_ptr_d == rd_ptr_d);
        // The output register always mirrors the head entry of the next cycle.
        if (push && (wr_ptr_q == rd_ptr_d)) begin
            data_d = wr_data_i;
        end else begin
            data_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            data_q   <= '0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
            empty_q  <= empty_d;
        end
    end

    assign rd_data_o = data_q;
    assign full_o    = full;
    assign empty_o   = empty_q;

endmodule

// File: rtl/multi_strobe_tagger.sv
// N-channel strobe front end: synchronises strobes, detects per-channel edges and queues
// timestamped records (plus timestamp rollover markers) into a FIFO drained as a stream.
module multi_strobe_tagger
    import multi_strobe_tagger_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned TS_W       = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned OVF_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      strobe_in,
    input  logic [N_CH-1:0]      chan_en,
    input  logic [N_CH-1:0]      falling_mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_CH+TS_W:0]   out_data,
    output logic                 overflow,
    output logic [OVF_W-1:0]     ovf_count,
    input  logic                 clear_ovf
);

    localparam int unsigned REC_W    = rec_w(N_CH, TS_W);
    localparam int unsigned TS_LSB   = ts_lsb();
    localparam int unsigned MASK_LSB = mask_lsb(TS_W);
    localparam int unsigned ROLL_BIT = rollover_bit(N_CH, TS_W);

    logic [N_CH-1:0]  edge_raw;
    logic [N_CH-1:0]  edge_q;
    logic [TS_W-1:0]  ts_q;
    arm_state_e       arm_state_q;
    logic             armed_q;
    logic             ts_zero;
    logic             wr_req;
    logic [REC_W-1:0] wr_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             drop;
    logic             overflow_q, overflow_d;
    logic [OVF_W-1:0] ovf_count_q, ovf_count_d;

    for (genvar g = 0; g < int'(N_CH); g++) begin : g_chan
        logic s1_q, s2_q, prev_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_q   <= 1'b0;
                s2_q   <= 1'b0;
                prev_q <= 1'b0;
            end else begin
                s1_q   <= strobe_in[g];
                s2_q   <= s1_q;
                prev_q <= s2_q;
            end
        end

        assign edge_raw[g] = (s2_q ^ falling_mask[g]) & ~(prev_q ^ falling_mask[g]) & chan_en[g];
    end

    // Levels present across reset reach the edge detector during the first three cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_state_q <= StArm0;
            armed_q     <= 1'b0;
        end else begin
            case (arm_state_q)
                StArm0:  arm_state_q <= StArm1;
                StArm1:  arm_state_q <= StArm2;
                StArm2: begin
                    arm_state_q <= StLive;
                    armed_q     <= 1'b1;
                end
                default: arm_state_q <= StLive;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_q <= '0;
            ts_q   <= '0;
        end else begin
            edge_q <= armed_q ? edge_raw : '0;
            ts_q   <= ts_q + TS_W'(1);
        end
    end

    assign ts_zero = (ts_q == '0);
    assign wr_req  = armed_q & ((|edge_q) | ts_zero);

    always_comb begin
        wr_data                         = '0;
        wr_data[TS_LSB +: TS_W]         = ts_q;
        wr_data[MASK_LSB +: N_CH]       = edge_q;
        wr_data[ROLL_BIT]               = ts_zero;
    end

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign drop      = wr_req & fifo_full & ~pop;

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_req),
        .wr_data_i (wr_data),
        .rd_en_i   (out_ready),
        .rd_data_o (out_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // A clear coinciding with a drop leaves exactly that one drop recorded.
    always_comb begin
        overflow_d  = overflow_q;
        ovf_count_d = ovf_count_q;
        if (clear_ovf) begin
            overflow_d  = drop;
            ovf_count_d = drop ? OVF_W'(1) : '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (ovf_count_q != '1) begin
                ovf_count_d = ovf_count_q + OVF_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            ovf_count_q <= '0;
        end else begin
            overflow_q  <= overflow_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign overflow  = overflow_q;
    assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_multi_strobe_tagger.sv
// Directed bench for multi_strobe_tagger: a 32-bit timestamp instance for the main checks
// and an 8-bit timestamp instance for rollover markers.
module tb_multi_strobe_tagger;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic [3:0]  strobe_in = '0;
    logic [3:0]  chan_en = 4'hF;
    logic [3:0]  falling_mask = '0;
    logic        out_ready = 1'b0;
    logic        clear_ovf = 1'b0;
    logic        out_valid;
    logic [36:0] out_data;
    logic        overflow;
    logic [15:0] ovf_count;

    logic        rst8 = 1'b0;
    logic [3:0]  strobe8 = '0;
    logic        valid8;
    logic [12:0] data8;
    logic        ovf8;
    logic [15:0] cnt8;

    multi_strobe_tagger #(.N_CH(4), .TS_W(32), .FIFO_DEPTH(16), .OVF_W(16)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .strobe_in    (strobe_in),
        .chan_en      (chan_en),
        .falling_mask (falling_mask),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .overflow     (overflow),
        .ovf_count    (ovf_count),
        .clear_ovf    (clear_ovf)
    );

    multi_strobe_tagger #(.N_CH(4), .TS_W(8), .FIFO_DEPTH(16), .OVF_W(16)) u_dut8 (
        .clk          (clk),
        .rst          (rst8),
        .strobe_in    (strobe8),
        .chan_en      (4'hF),
        .falling_mask (4'h0),
        .out_valid    (valid8),
        .out_ready    (1'b1),
        .out_data     (data8),
        .overflow     (ovf8),
        .ovf_count    (cnt8),
        .clear_ovf    (1'b0)
    );

    typedef struct {
        logic [3:0] pre;
        logic [3:0] post;
        logic [3:0] en;
        logic [3:0] fm;
        logic       exp_valid;
        logic [3:0] exp_mask;
    } vec_t;

    vec_t        vecs [8];
    logic [36:0] expv [20];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          base;
    int          n8;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic pulse_ch0();
        strobe_in = 4'b0001;
        tick();
        strobe_in = 4'b0000;
        tick();
    endtask

    initial begin
        vecs[0] = '{pre: 4'b0000, post: 4'b0100, en: 4'hF, fm: 4'h0, exp_valid: 1'b1, exp_mask: 4'b0100};
        vecs[1] = '{pre: 4'b0000, post: 4'b1001, en: 4'hF, fm: 4'h0, exp_valid: 1'b1, exp_mask: 4'b1001};
        vecs[2] = '{pre: 4'b1111, post: 4'b0000, en: 4'hF, fm: 4'hF, exp_valid: 1'b1, exp_mask: 4'b1111};
        vecs[3] = '{pre: 4'b1111, post: 4'b0000, en: 4'hF, fm: 4'h0, exp_valid: 1'b0, exp_mask: 4'b0000};
        vecs[4] = '{pre: 4'b0000, post: 4'b1111, en: 4'b0101, fm: 4'h0, exp_valid: 1'b1, exp_mask: 4'b0101};
        vecs[5] = '{pre: 4'b0011, post: 4'b1100, en: 4'hF, fm: 4'b0011, exp_valid: 1'b1, exp_mask: 4'b1111};
        vecs[6] = '{pre: 4'b0011, post: 4'b1100, en: 4'hF, fm: 4'h0, exp_valid: 1'b1, exp_mask: 4'b1100};
        vecs[7] = '{pre: 4'b0000, post: 4'b0010, en: 4'h0, fm: 4'h0, exp_valid: 1'b0, exp_mask: 4'b0000};

        // Level held through reset must never produce a record.
        #1;
        rst  = 1'b1;
        rst8 = 1'b1;
        strobe_in = 4'b0001;
        tick();
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_ovf_count", ovf_count, 0);
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            check("arm_no_record", out_valid, 0);
            tick();
        end
        strobe_in = 4'b0000;

        // Single rising pulse at ts=100 appears four clocks later stamped 103.
        while (cyc < 100) tick();
        strobe_in = 4'b0100;
        repeat (3) tick();
        check("ch2_not_early", out_valid, 0);
        tick();
        check("ch2_valid", out_valid, 1);
        check("ch2_data", out_data, {1'b0, 4'b0100, 32'd103});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("ch2_single", out_valid, 0);
        strobe_in = 4'b0000;
        repeat (4) tick();
        check("ch2_fall_ignored", out_valid, 0);

        for (int v = 0; v < 8; v++) begin
            chan_en   = 4'h0;
            strobe_in = vecs[v].pre;
            repeat (4) tick();
            chan_en      = vecs[v].en;
            falling_mask = vecs[v].fm;
            tick();
            strobe_in = vecs[v].post;
            base = cyc;
            repeat (4) tick();
            check($sformatf("vec%0d_valid", v), out_valid, vecs[v].exp_valid);
            if (vecs[v].exp_valid) begin
                check($sformatf("vec%0d_data", v), out_data,
                      {1'b0, vecs[v].exp_mask, 32'(base + 3)});
            end
            if (out_valid) begin
                out_ready = 1'b1;
                tick();
                out_ready = 1'b0;
            end
            repeat (3) tick();
            check($sformatf("vec%0d_idle", v), out_valid, 0);
        end

        // Disabling a channel while its edge is still in the synchroniser drops that edge.
        chan_en = 4'hF;
        falling_mask = 4'h0;
        strobe_in = 4'b0000;
        repeat (4) tick();
        strobe_in = 4'b0010;
        tick();
        chan_en = 4'h0;
        repeat (2) tick();
        chan_en = 4'hF;
        repeat (4) tick();
        check("en_masks_inflight", out_valid, 0);
        strobe_in = 4'b0000;

        // Overflow: 20 edges into a 16-deep FIFO with the consumer stalled.
        do_reset();
        repeat (4) tick();
        for (int k = 0; k < 20; k++) begin
            expv[k] = {1'b0, 4'b0001, 32'(cyc + 3)};
            pulse_ch0();
        end
        repeat (6) tick();
        check("ovf_flag", overflow, 1);
        check("ovf_count4", ovf_count, 4);
        check("ovf_head", out_data, expv[0]);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", out_valid, 1);
            check("stall_stable", out_data, expv[0]);
        end
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("clear_flag", overflow, 0);
        check("clear_count", ovf_count, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain%0d_valid", i), out_valid, 1);
            check($sformatf("drain%0d_data", i), out_data, expv[i]);
            tick();
        end
        out_ready = 1'b0;
        check("drain_empty", out_valid, 0);

        // Full FIFO with a read and a write in the same cycle: nothing dropped.
        do_reset();
        repeat (4) tick();
        for (int k = 0; k < 16; k++) begin
            expv[k] = {1'b0, 4'b0001, 32'(cyc + 3)};
            pulse_ch0();
        end
        repeat (4) tick();
        check("full_no_drop_yet", ovf_count, 0);
        expv[16] = {1'b0, 4'b0001, 32'(cyc + 3)};
        strobe_in = 4'b0001;
        tick();
        strobe_in = 4'b0000;
        repeat (2) tick();
        check("rw_head", out_data, expv[0]);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        check("rw_no_overflow", overflow, 0);
        check("rw_count", ovf_count, 0);
        check("rw_new_head", out_data, expv[1]);

        // Two drops, then a drop coinciding with clear_ovf.
        pulse_ch0();
        pulse_ch0();
        repeat (4) tick();
        check("drop2_count", ovf_count, 2);
        strobe_in = 4'b0001;
        tick();
        strobe_in = 4'b0000;
        repeat (2) tick();
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("clear_drop_flag", overflow, 1);
        check("clear_drop_count", ovf_count, 1);

        out_ready = 1'b1;
        for (int i = 1; i < 6; i++) begin
            check($sformatf("order%0d", i), out_data, expv[i]);
            tick();
        end
        // Asynchronous reset mid-stream.
        rst = 1'b1;
        #1;
        check("rst_async_valid", out_valid, 0);
        tick();
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_data", out_data, 0);
        check("rst_mid_overflow", overflow, 0);
        check("rst_mid_count", ovf_count, 0);
        rst = 1'b0;
        cyc = 0;
        out_ready = 1'b0;
        repeat (10) tick();
        check("rst_fifo_discarded", out_valid, 0);
        strobe_in = 4'b0100;
        base = cyc;
        repeat (4) tick();
        check("rst_ts_restart", out_data, {1'b0, 4'b0100, 32'(base + 3)});
        strobe_in = 4'b0000;

        // 8-bit timestamp: one pure rollover record per wrap.
        rst8 = 1'b0;
        base = cyc;
        n8 = 0;
        while (cyc - base < 600) begin
            tick();
            if (valid8) begin
                check("wrap_data", data8, 13'h1000);
                check("wrap_pos", cyc - base, (n8 == 0) ? 257 : 513);
                n8++;
            end
        end
        check("wrap_count", n8, 2);
        while (cyc - base < 765) tick();
        strobe8 = 4'b0010;
        n8 = 0;
        while (cyc - base < 780) begin
            tick();
            if (valid8) begin
                check("wrap_edge_data", data8, 13'h1200);
                check("wrap_edge_pos", cyc - base, 769);
                n8++;
            end
        end
        check("wrap_edge_count", n8, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
